// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and register map for the MMIO UART transmitter
package uart_pkg;

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } tx_state_t;

   // Register offsets within the 16-byte window (A[3:0])
   localparam logic [3:0] OFS_TXDATA  = 4'h0;
   localparam logic [3:0] OFS_STATUS  = 4'h4;
   localparam logic [3:0] OFS_BAUDDIV = 4'h8;
   localparam logic [3:0] OFS_CTRL    = 4'hC;

   // STATUS bit positions
   localparam int STAT_FULL      = 0;
   localparam int STAT_EMPTY     = 1;
   localparam int STAT_BUSY      = 2;
   localparam int STAT_OVERFLOW  = 3;
   localparam int STAT_COUNT_LSB = 8;

   // A divisor of zero would stall the baud counter, so it is stored as 1.
   function automatic logic [15:0] clampDiv(input logic [15:0] div);
      return (div == 16'd0) ? 16'd1 : div;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with show-ahead read data
// Ports:
//   clk, reset         clock, synchronous active-high reset
//   push, pushData     write request and data; ignored while full
//   pop, popData       read request; popData always shows the head entry
//   full, empty, count occupancy flags and entry count
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic [WIDTH-1:0]         pushData,
   input  logic                     pop,
   output logic [WIDTH-1:0]         popData,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wrPtr;
   logic [AW-1:0]    rdPtr;
   logic             doPush;
   logic             doPop;

   assign doPush  = push && !full;
   assign doPop   = pop && !empty;
   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign popData = mem[rdPtr];

   always_ff @(posedge clk) begin
      if (doPush) begin
         mem[wrPtr] <= pushData;
      end
   end

   // DEPTH is a power of two, so the pointers wrap naturally.
   always_ff @(posedge clk) begin
      if (reset) begin
         wrPtr <= '0;
         rdPtr <= '0;
         count <= '0;
      end else begin
         if (doPush) begin
            wrPtr <= wrPtr + AW'(1);
         end
         if (doPop) begin
            rdPtr <= rdPtr + AW'(1);
         end
         case ({doPush, doPop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/mmio_uart_tx.sv
// rtl/mmio_uart_tx.sv - memory-mapped 8N1 UART transmitter on the processor data bus
// Ports:
//   clk, reset   clock, synchronous active-high reset
//   WE, A, WD    bus write strobe, byte address, write data
//   RD           combinational read data, 0 when the window is not addressed
//   tx           serial line, idle high
//   irq          (only with UART_TX_IRQ_EN) transmitter drained and idle
// Optional feature macro: UART_TX_IRQ_EN (adds CTRL.irqEn and the irq output)
module mmio_uart_tx
   import uart_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR   = 32'hFFFF_0000,
   parameter int          FIFO_DEPTH  = 8,
   parameter logic [15:0] DEFAULT_DIV = 16'd868
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        WE,
   input  logic [31:0] A,
   input  logic [31:0] WD,
   output logic [31:0] RD,
   output logic        tx
`ifdef UART_TX_IRQ_EN
   ,
   output logic        irq
`endif
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   // Address decode
   logic       sel;
   logic [3:0] ofs;
   logic       wrTxData;
   logic       wrStatus;
   logic       wrBaud;

   assign sel      = (A[31:4] == BASE_ADDR[31:4]);
   assign ofs      = A[3:0];
   assign wrTxData = WE && sel && (ofs == OFS_TXDATA);
   assign wrStatus = WE && sel && (ofs == OFS_STATUS);
   assign wrBaud   = WE && sel && (ofs == OFS_BAUDDIV);

   logic unusedWdHigh;
   assign unusedWdHigh = ^WD[31:16];

   // TX FIFO
   logic          fifoPop;
   logic [7:0]    fifoHead;
   logic          fifoFull;
   logic          fifoEmpty;
   logic [CW-1:0] fifoCount;

   sync_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) txFifo (
      .clk      (clk),
      .reset    (reset),
      .push     (wrTxData),
      .pushData (WD[7:0]),
      .pop      (fifoPop),
      .popData  (fifoHead),
      .full     (fifoFull),
      .empty    (fifoEmpty),
      .count    (fifoCount)
   );

   // Register file
   logic        overflow;
   logic [15:0] baudDiv;

   always_ff @(posedge clk) begin
      if (reset) begin
         overflow <= 1'b0;
         baudDiv  <= DEFAULT_DIV;
      end else begin
         // A push that is dropped wins over a clear in the same cycle; they
         // target different offsets so they can never coincide anyway.
         if (wrTxData && fifoFull) begin
            overflow <= 1'b1;
         end else if (wrStatus && WD[STAT_OVERFLOW]) begin
            overflow <= 1'b0;
         end
         if (wrBaud) begin
            baudDiv <= clampDiv(WD[15:0]);
         end
      end
   end

   // Serializer FSM
   tx_state_t   state;
   tx_state_t   nextState;
   logic        txReg;
   logic        txNext;
   logic [7:0]  shiftReg;
   logic [7:0]  shiftNext;
   logic [2:0]  bitCnt;
   logic [2:0]  bitNext;
   logic [15:0] baudCnt;
   logic [15:0] baudNext;
   logic [15:0] divLatched;
   logic [15:0] divNext;
   logic        baudDone;
   logic        startFrame;

   assign baudDone = (baudCnt == 16'd0);
   assign tx       = txReg;

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         txReg      <= 1'b1;
         shiftReg   <= 8'd0;
         bitCnt     <= 3'd0;
         baudCnt    <= 16'd0;
         divLatched <= DEFAULT_DIV;
      end else begin
         state      <= nextState;
         txReg      <= txNext;
         shiftReg   <= shiftNext;
         bitCnt     <= bitNext;
         baudCnt    <= baudNext;
         divLatched <= divNext;
      end
   end

   always_comb begin
      nextState  = state;
      txNext     = txReg;
      shiftNext  = shiftReg;
      bitNext    = bitCnt;
      baudNext   = baudCnt;
      divNext    = divLatched;
      fifoPop    = 1'b0;
      startFrame = 1'b0;

      case (state)
         IDLE: begin
            startFrame = !fifoEmpty;
         end
         START: begin
            if (baudDone) begin
               nextState = DATA;
               txNext    = shiftReg[0];
               shiftNext = shiftReg >> 1;
               bitNext   = 3'd0;
               baudNext  = divLatched - 16'd1;
            end else begin
               baudNext  = baudCnt - 16'd1;
            end
         end
         DATA: begin
            if (baudDone) begin
               baudNext = divLatched - 16'd1;
               if (bitCnt == 3'd7) begin
                  nextState = STOP;
                  txNext    = 1'b1;
               end else begin
                  txNext    = shiftReg[0];
                  shiftNext = shiftReg >> 1;
                  bitNext   = bitCnt + 3'd1;
               end
            end else begin
               baudNext = baudCnt - 16'd1;
            end
         end
         STOP: begin
            if (baudDone) begin
               // Chaining straight into the next start bit keeps frames gap-free.
               if (!fifoEmpty) begin
                  startFrame = 1'b1;
               end else begin
                  nextState = IDLE;
               end
            end else begin
               baudNext = baudCnt - 16'd1;
            end
         end
         default: begin
            nextState = IDLE;
            txNext    = 1'b1;
         end
      endcase

      // The divisor is captured here so BAUDDIV writes never stretch a frame
      // that is already on the wire.
      if (startFrame) begin
         nextState = START;
         fifoPop   = 1'b1;
         txNext    = 1'b0;
         shiftNext = fifoHead;
         divNext   = baudDiv;
         baudNext  = baudDiv - 16'd1;
      end
   end

   logic busy;
   assign busy = (state != IDLE);

   // Optional interrupt
   logic [31:0] ctrlWord;

`ifdef UART_TX_IRQ_EN
   logic irqEn;
   logic wrCtrl;

   assign wrCtrl = WE && sel && (ofs == OFS_CTRL);

   always_ff @(posedge clk) begin
      if (reset) begin
         irqEn <= 1'b0;
         irq   <= 1'b0;
      end else begin
         if (wrCtrl) begin
            irqEn <= WD[0];
         end
         irq <= irqEn && fifoEmpty && !busy;
      end
   end

   assign ctrlWord = {31'd0, irqEn};
`else
   assign ctrlWord = 32'd0;
`endif

   // Read mux
   logic [31:0] statusWord;

   always_comb begin
      statusWord                          = 32'd0;
      statusWord[STAT_FULL]               = fifoFull;
      statusWord[STAT_EMPTY]              = fifoEmpty;
      statusWord[STAT_BUSY]               = busy;
      statusWord[STAT_OVERFLOW]           = overflow;
      statusWord[STAT_COUNT_LSB +: 8]     = 8'(fifoCount);
   end

   always_comb begin
      RD = 32'd0;
      if (sel) begin
         case (ofs)
            OFS_STATUS:  RD = statusWord;
            OFS_BAUDDIV: RD = {16'd0, baudDiv};
            OFS_CTRL:    RD = ctrlWord;
            default:     RD = 32'd0;
         endcase
      end
   end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb/tb_mmio_uart_tx.sv - self-checking bench for mmio_uart_tx
module tb_mmio_uart_tx;

   localparam logic [31:0] BASE  = 32'hFFFF_0000;
   localparam logic [31:0] ATX   = BASE + 32'h0;
   localparam logic [31:0] ASTAT = BASE + 32'h4;
   localparam logic [31:0] ABAUD = BASE + 32'h8;
   localparam logic [31:0] ACTRL = BASE + 32'hC;
   localparam int          DEPTH = 8;
`ifdef UART_TX_IRQ_EN
   localparam logic [31:0] CTRL_ONE = 32'd1;
`else
   localparam logic [31:0] CTRL_ONE = 32'd0;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        WE = 1'b0;
   logic [31:0] A = 32'd0;
   logic [31:0] WD = 32'd0;
   logic [31:0] RD;
   logic        tx;
`ifdef UART_TX_IRQ_EN
   logic        irq;
`endif

   int checks = 0;
   int failures = 0;

   mmio_uart_tx dut (
      .clk   (clk),
      .reset (reset),
      .WE    (WE),
      .A     (A),
      .WD    (WD),
      .RD    (RD),
      .tx    (tx)
`ifdef UART_TX_IRQ_EN
      ,
      .irq   (irq)
`endif
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h required 0x%08h", name, got, exp);
      end
   endtask

   task automatic busWrite(input logic [31:0] addr, input logic [31:0] data);
      WE = 1'b1;
      A  = addr;
      WD = data;
      tick();
      WE = 1'b0;
      A  = 32'd0;
   endtask

   task automatic readReg(input logic [31:0] addr, output logic [31:0] data);
      A = addr;
      #1;
      data = RD;
   endtask

   task automatic doReset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   // Expected serial waveform, one entry per clock after the reference edge
   logic expQ[$];

   task automatic appendFrame(input logic [7:0] b, input int div);
      logic bitVal;
      for (int k = 0; k < 10; k++) begin
         if (k == 0)      bitVal = 1'b0;
         else if (k == 9) bitVal = 1'b1;
         else             bitVal = b[k-1];
         for (int j = 0; j < div; j++) expQ.push_back(bitVal);
      end
   endtask

   task automatic runWave(input string name,
                          input int wi0, input logic [31:0] wa0, input logic [31:0] wd0,
                          input int wi1, input logic [31:0] wa1, input logic [31:0] wd1);
      int   bad;
      logic got;
      logic want;
      bad = -1;
      got = 1'b0;
      want = 1'b0;
      for (int i = 0; i < expQ.size(); i++) begin
         if (i == wi0) begin
            WE = 1'b1; A = wa0; WD = wd0;
         end else if (i == wi1) begin
            WE = 1'b1; A = wa1; WD = wd1;
         end else begin
            WE = 1'b0; A = ASTAT;
         end
         tick();
         if (tx !== expQ[i] && bad < 0) begin
            bad = i; got = tx; want = expQ[i];
         end
      end
      WE = 1'b0;
      checks++;
      if (bad >= 0) begin
         failures++;
         $display("FAIL %s: cycle %0d tx=%b required %b", name, bad, got, want);
      end
   endtask

   // Register access vectors applied from idle
   typedef struct {
      logic        we;
      logic [31:0] wa;
      logic [31:0] wd;
      logic [31:0] ra;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs[$];

   // Behavioural reference model for the random phase
   int   mq[$];
   int   mDiv;
   int   mFrameDiv;
   int   mT;
   int   mByte;
   logic mActive;
   logic mOvf;

   function automatic logic [31:0] modelStatus();
      logic [31:0] s;
      s = 32'd0;
      s[0] = (mq.size() == DEPTH);
      s[1] = (mq.size() == 0);
      s[2] = mActive;
      s[3] = mOvf;
      s[15:8] = 8'(mq.size());
      return s;
   endfunction

   function automatic logic modelTx();
      int idx;
      logic [7:0] b;
      if (!mActive) return 1'b1;
      idx = mT / mFrameDiv;
      b = 8'(mByte);
      if (idx == 0) return 1'b0;
      if (idx == 9) return 1'b1;
      return b[idx-1];
   endfunction

   int rndTxBad = 0;

   task automatic rndStep(input logic we, input logic [31:0] a, input logic [31:0] wd);
      int preSize;
      logic [31:0] word;
      WE = we; A = a; WD = wd;
      #1;
      if (!we && a == ASTAT) check("rnd_status", RD, modelStatus());
      if (!we && a == ABAUD) check("rnd_bauddiv", RD, 32'(mDiv));
      @(posedge clk);
      #1;
      preSize = mq.size();
      if (mActive) begin
         mT++;
         if (mT == 10 * mFrameDiv) mActive = 1'b0;
      end
      if (!mActive && preSize > 0) begin
         mByte = mq.pop_front();
         mActive = 1'b1;
         mT = 0;
         mFrameDiv = mDiv;
      end
      if (we && a[31:4] == BASE[31:4]) begin
         word = wd;
         case (a[3:0])
            4'h0: if (preSize == DEPTH) mOvf = 1'b1; else mq.push_back(int'(word[7:0]));
            4'h4: if (word[3]) mOvf = 1'b0;
            4'h8: mDiv = (word[15:0] == 16'd0) ? 1 : int'(word[15:0]);
            default: ;
         endcase
      end
      checks++;
      if (tx !== modelTx()) begin
         failures++;
         rndTxBad++;
         if (rndTxBad <= 5) $display("FAIL rnd_tx: tx=%b required %b", tx, modelTx());
      end
   endtask

   initial begin
      logic [31:0] r;
      int op;

      // Reset state
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      check("reset_tx", {31'd0, tx}, 32'd1);
      readReg(ASTAT, r);
      check("reset_status", r, 32'h0000_0002);
      readReg(ABAUD, r);
      check("reset_bauddiv", r, 32'd868);

      // Register vectors
      vecs.push_back('{1'b0, 32'd0,          32'd0,          ABAUD,         32'd868});
      vecs.push_back('{1'b0, 32'd0,          32'd0,          ATX,           32'd0});
      vecs.push_back('{1'b1, ABAUD,          32'd5,          ABAUD,         32'd5});
      vecs.push_back('{1'b1, ABAUD,          32'd0,          ABAUD,         32'd1});
      vecs.push_back('{1'b1, ABAUD,          32'hABCD_0007,  ABAUD,         32'd7});
      vecs.push_back('{1'b1, 32'hFFFE_0008,  32'd9,          ABAUD,         32'd7});
      vecs.push_back('{1'b0, 32'd0,          32'd0,          32'hFFFE_0008, 32'd0});
      vecs.push_back('{1'b0, 32'd0,          32'd0,          BASE + 32'h2,  32'd0});
      vecs.push_back('{1'b1, BASE + 32'h6,   32'd5,          ABAUD,         32'd7});
      vecs.push_back('{1'b1, ACTRL,          32'd1,          ACTRL,         CTRL_ONE});
      vecs.push_back('{1'b1, ACTRL,          32'd0,          ACTRL,         32'd0});
      vecs.push_back('{1'b1, ABAUD,          32'h0000_FFFF,  ABAUD,         32'h0000_FFFF});
      vecs.push_back('{1'b1, 32'h0000_0000,  32'h55,         ASTAT,         32'h0000_0002});
      for (int i = 0; i < vecs.size(); i++) begin
         if (vecs[i].we) busWrite(vecs[i].wa, vecs[i].wd);
         readReg(vecs[i].ra, r);
         check($sformatf("regvec%0d", i), r, vecs[i].exp);
      end

      // 0x55 at DIV=4: one-cycle latency, 40-cycle frame
      busWrite(ABAUD, 32'd4);
      busWrite(ATX, 32'h55);
      check("latency_tx_still_high", {31'd0, tx}, 32'd1);
      expQ.delete();
      appendFrame(8'h55, 4);
      expQ.push_back(1'b1);
      expQ.push_back(1'b1);
      runWave("wave_55_div4", -1, 32'd0, 32'd0, -1, 32'd0, 32'd0);
      readReg(ASTAT, r);
      check("status_after_55", r, 32'h0000_0002);

      // Back-to-back frames at DIV=2
      busWrite(ABAUD, 32'd2);
      busWrite(ATX, 32'hA5);
      expQ.delete();
      appendFrame(8'hA5, 2);
      appendFrame(8'h3C, 2);
      expQ.push_back(1'b1);
      expQ.push_back(1'b1);
      runWave("wave_a5_3c", 0, ATX, 32'h3C, -1, 32'd0, 32'd0);
      readReg(ASTAT, r);
      check("status_after_b2b", r, 32'h0000_0002);

      // Mid-frame divisor change applies to the next frame only
      busWrite(ABAUD, 32'd2);
      busWrite(ATX, 32'h0F);
      expQ.delete();
      appendFrame(8'h0F, 2);
      appendFrame(8'hC3, 8);
      expQ.push_back(1'b1);
      expQ.push_back(1'b1);
      runWave("wave_div_change", 0, ATX, 32'hC3, 5, ABAUD, 32'd8);
      readReg(ABAUD, r);
      check("bauddiv_after_change", r, 32'd8);

      // Overflow with slow baud
      busWrite(ABAUD, 32'd868);
      for (int i = 0; i < 9; i++) busWrite(ATX, 32'(i + 1));
      readReg(ASTAT, r);
      check("status_fifo_full", r, 32'h0000_0805);
      busWrite(ATX, 32'hEE);
      readReg(ASTAT, r);
      check("status_overflow_set", r, 32'h0000_080D);
      busWrite(ASTAT, 32'h7);
      readReg(ASTAT, r);
      check("overflow_not_cleared", r, 32'h0000_080D);
      busWrite(ASTAT, 32'h8);
      readReg(ASTAT, r);
      check("overflow_cleared", r, 32'h0000_0805);
      doReset();

      // Reset during DATA bit 3 with three bytes queued
      busWrite(ABAUD, 32'd4);
      for (int i = 0; i < 4; i++) busWrite(ATX, 32'h00);
      for (int i = 0; i < 15; i++) tick();
      check("midframe_tx_low", {31'd0, tx}, 32'd0);
      readReg(ASTAT, r);
      check("midframe_status", r, 32'h0000_0304);
      reset = 1'b1;
      tick();
      check("reset_abort_tx", {31'd0, tx}, 32'd1);
      reset = 1'b0;
      readReg(ASTAT, r);
      check("reset_abort_status", r, 32'h0000_0002);
      readReg(ABAUD, r);
      check("reset_abort_bauddiv", r, 32'd868);
      for (int i = 0; i < 6; i++) tick();
      check("reset_abort_stays_idle", {31'd0, tx}, 32'd1);

`ifdef UART_TX_IRQ_EN
      begin
         int irqBad;
         doReset();
         busWrite(ABAUD, 32'd2);
         busWrite(ACTRL, 32'd1);
         tick();
         check("irq_idle_enabled", {31'd0, irq}, 32'd1);
         busWrite(ATX, 32'h81);
         irqBad = 0;
         for (int i = 0; i < 21; i++) begin
            tick();
            if (irq !== 1'b0) irqBad++;
         end
         check("irq_low_during_frame", 32'(irqBad), 32'd0);
         tick();
         check("irq_after_stop", {31'd0, irq}, 32'd1);
         busWrite(ACTRL, 32'd0);
         tick();
         check("irq_disabled", {31'd0, irq}, 32'd0);
      end
`endif

      // Randomized traffic against the reference model
      doReset();
      mq.delete();
      mDiv = 868;
      mFrameDiv = 1;
      mT = 0;
      mByte = 0;
      mActive = 1'b0;
      mOvf = 1'b0;
      rndStep(1'b1, ABAUD, 32'd3);
      for (int c = 0; c < 4000; c++) begin
         op = $urandom_range(0, 99);
         if (op < 12)      rndStep(1'b1, ATX, $urandom);
         else if (op < 15) rndStep(1'b1, ABAUD, {$urandom_range(0, 65535) & 32'hFFFF_0000} | 32'($urandom_range(0, 4)));
         else if (op < 18) rndStep(1'b1, ASTAT, $urandom);
         else if (op < 21) rndStep(1'b1, 32'hFFFE_0000, $urandom);
         else if (op < 23) rndStep(1'b1, BASE + 32'h3, $urandom);
         else if (op < 30) rndStep(1'b0, ABAUD, 32'd0);
         else              rndStep(1'b0, ASTAT, 32'd0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
